// File: rtl/cpl_timeout_sched.sv
// cpl_timeout_sched: tracks 4 outstanding non-posted requests and reports completion timeouts.
// Optional feature: define CPL_TIMEOUT_DISABLE_EN to let devctl2[8] freeze all pending timers.
module cpl_timeout_sched #(
  parameter int PRESCALE = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] devctl2,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [1:0]  alloc_tag,
  input  logic        cpl_valid,
  input  logic [1:0]  cpl_tag,
  output logic        cpl_unexpected,
  output logic        timeout_valid,
  output logic [1:0]  timeout_tag,
  input  logic        timeout_ready,
  output logic [2:0]  outstanding
);

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_PEND    = 2'd1,
    SLOT_EXPIRED = 2'd2
  } slot_state_e;

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  slot_state_e   state_r     [4];
  slot_state_e   state_nxt_s [4];
  logic [16:0]   cnt_r       [4];
  logic [16:0]   cnt_nxt_s   [4];
  logic [PW-1:0] presc_r;
  logic          tick_s;
  logic          freeze_s;
  logic          exp_any_s;
  logic [1:0]    exp_idx_s;
  logic [2:0]    busy_nxt_s;
  logic          timeout_valid_r;
  logic [1:0]    timeout_tag_r;
  logic          cpl_unexpected_r;
  logic [2:0]    outstanding_r;
  logic          unused_s;

  // LIMIT = (value+1) << 4*min(range,3); range is devctl2[7:4], value is devctl2[3:0].
  function automatic logic [16:0] calc_limit(input logic [7:0] ctl);
    logic [16:0] base;
    logic [3:0]  sh;
    base = 17'(ctl[3:0]) + 17'd1;
    sh   = (ctl[7:4] >= 4'd3) ? 4'd12 : {ctl[5:4], 2'b00};
    return base << sh;
  endfunction

`ifdef CPL_TIMEOUT_DISABLE_EN
  assign freeze_s = devctl2[8];
  assign unused_s = ^devctl2[15:9];
`else
  assign freeze_s = 1'b0;
  assign unused_s = ^devctl2[15:8];
`endif

  assign tick_s         = (presc_r == PRESC_LAST);
  assign cpl_unexpected = cpl_unexpected_r;
  assign timeout_valid  = timeout_valid_r;
  assign timeout_tag    = timeout_tag_r;
  assign outstanding    = outstanding_r;

  // Lowest-index free slot (grant) and lowest-index expired slot (next report).
  always_comb begin
    req_ready = 1'b0;
    alloc_tag = 2'd0;
    exp_any_s = 1'b0;
    exp_idx_s = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      case (state_r[i])
        SLOT_FREE: begin
          req_ready = 1'b1;
          alloc_tag = 2'(i);
        end
        SLOT_EXPIRED: begin
          exp_any_s = 1'b1;
          exp_idx_s = 2'(i);
        end
        default: begin
          exp_any_s = exp_any_s;
        end
      endcase
    end
  end

  // Completion or report acceptance frees a slot ahead of any same-cycle expiry.
  always_comb begin
    busy_nxt_s = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if ((cpl_valid && (cpl_tag == 2'(i)) && (state_r[i] == SLOT_PEND)) ||
          (timeout_valid_r && timeout_ready && (timeout_tag_r == 2'(i)))) begin
        state_nxt_s[i] = SLOT_FREE;
        cnt_nxt_s[i]   = 17'd0;
      end else if (req_valid && req_ready && (alloc_tag == 2'(i))) begin
        state_nxt_s[i] = SLOT_PEND;
        cnt_nxt_s[i]   = calc_limit(devctl2[7:0]);
      end else if ((state_r[i] == SLOT_PEND) && tick_s && !freeze_s) begin
        state_nxt_s[i] = (cnt_r[i] == 17'd1) ? SLOT_EXPIRED : SLOT_PEND;
        cnt_nxt_s[i]   = cnt_r[i] - 17'd1;
      end else begin
        state_nxt_s[i] = state_r[i];
        cnt_nxt_s[i]   = cnt_r[i];
      end
      busy_nxt_s = busy_nxt_s + ((state_nxt_s[i] != SLOT_FREE) ? 3'd1 : 3'd0);
    end
  end

  // Slot state, counters, prescaler and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        state_r[i] <= SLOT_FREE;
        cnt_r[i]   <= 17'd0;
      end
      presc_r          <= {PW{1'b0}};
      timeout_valid_r  <= 1'b0;
      timeout_tag_r    <= 2'd0;
      cpl_unexpected_r <= 1'b0;
      outstanding_r    <= 3'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_r[i] <= state_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
      end
      presc_r          <= tick_s ? {PW{1'b0}} : (presc_r + PW'(1'b1));
      cpl_unexpected_r <= cpl_valid && (state_r[cpl_tag] != SLOT_PEND);
      outstanding_r    <= busy_nxt_s;
      // A held report stays put until accepted; a new one starts a cycle later.
      if (timeout_valid_r && timeout_ready) begin
        timeout_valid_r <= 1'b0;
      end else if (!timeout_valid_r && exp_any_s) begin
        timeout_valid_r <= 1'b1;
        timeout_tag_r   <= exp_idx_s;
      end else begin
        timeout_valid_r <= timeout_valid_r;
        timeout_tag_r   <= timeout_tag_r;
      end
    end
  end

endmodule

// File: tb/tb_cpl_timeout_sched.sv
// Scoreboard bench for cpl_timeout_sched: a slot-level reference model predicts every cycle's outputs.
module tb_cpl_timeout_sched;
  localparam int P = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] devctl2 = 16'h0000;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  alloc_tag;
  logic        cpl_valid = 1'b0;
  logic [1:0]  cpl_tag = 2'd0;
  logic        cpl_unexpected;
  logic        timeout_valid;
  logic [1:0]  timeout_tag;
  logic        timeout_ready = 1'b0;
  logic [2:0]  outstanding;

  cpl_timeout_sched #(.PRESCALE(P)) dut (
    .clk(clk), .reset_n(reset_n), .devctl2(devctl2),
    .req_valid(req_valid), .req_ready(req_ready), .alloc_tag(alloc_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_unexpected(cpl_unexpected),
    .timeout_valid(timeout_valid), .timeout_tag(timeout_tag), .timeout_ready(timeout_ready),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rdy; int atag; bit unexp; bit tv; int ttag; int outs;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: 0 = free, 1 = pending, 2 = expired; rem counts ticks left.
  int st[4];
  int rem[4];
  int cyc;
  bit rep_v;
  int rep_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int limit_of(input logic [15:0] ctl);
    int rng;
    rng = (int'(ctl[7:4]) > 3) ? 3 : int'(ctl[7:4]);
    return (int'(ctl[3:0]) + 1) * (1 << (4 * rng));
  endfunction

  // Drive one cycle at the negedge, advance the model and queue its prediction.
  task automatic step(input bit rv, input bit cv, input logic [1:0] ct, input bit tr);
    exp_t e;
    int   nst[4];
    int   nrem[4];
    bit   tick, frz;
    int   g;
    req_valid = rv; cpl_valid = cv; cpl_tag = ct; timeout_ready = tr;
    tick = ((cyc % P) == P - 1);
`ifdef CPL_TIMEOUT_DISABLE_EN
    frz = devctl2[8];
`else
    frz = 1'b0;
`endif
    nst = st;
    nrem = rem;
    g = -1;
    for (int i = 3; i >= 0; i--) if (st[i] == 0) g = i;
    for (int i = 0; i < 4; i++) begin
      if (st[i] == 1 && tick && !frz) begin
        nrem[i]--;
        if (nrem[i] == 0) nst[i] = 2;
      end
    end
    if (rv && g >= 0) begin
      nst[g] = 1;
      nrem[g] = limit_of(devctl2);
    end
    e.unexp = 1'b0;
    if (cv) begin
      if (st[ct] == 1) nst[ct] = 0;
      else e.unexp = 1'b1;
    end
    if (rep_v && tr) begin
      nst[rep_t] = 0;
      rep_v = 1'b0;
    end else if (!rep_v) begin
      for (int i = 3; i >= 0; i--) begin
        if (st[i] == 2) begin
          rep_v = 1'b1;
          rep_t = i;
        end
      end
    end
    st = nst;
    rem = nrem;
    cyc++;
    e.outs = 0;
    e.rdy = 1'b0;
    e.atag = 0;
    for (int i = 3; i >= 0; i--) begin
      if (st[i] != 0) e.outs++;
      else begin
        e.rdy = 1'b1;
        e.atag = i;
      end
    end
    e.tv = rep_v;
    e.ttag = rep_t;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tagname);
    check({tagname, "_req_ready"}, req_ready, 1);
    check({tagname, "_alloc_tag"}, alloc_tag, 0);
    check({tagname, "_timeout_valid"}, timeout_valid, 0);
    check({tagname, "_timeout_tag"}, timeout_tag, 0);
    check({tagname, "_cpl_unexpected"}, cpl_unexpected, 0);
    check({tagname, "_outstanding"}, outstanding, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = 1'b0; cpl_valid = 1'b0; timeout_ready = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_held");
    for (int i = 0; i < 4; i++) begin
      st[i] = 0;
      rem[i] = 0;
    end
    cyc = 0;
    rep_v = 1'b0;
    rep_t = 0;
    reset_n = 1'b1;
  endtask

  // Monitor: compare every post-edge output set against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mon_req_ready", req_ready, e.rdy);
        if (e.rdy) check("mon_alloc_tag", alloc_tag, e.atag);
        check("mon_cpl_unexpected", cpl_unexpected, e.unexp);
        check("mon_timeout_valid", timeout_valid, e.tv);
        if (e.tv) check("mon_timeout_tag", timeout_tag, e.ttag);
        check("mon_outstanding", outstanding, e.outs);
      end
    end
  end

  initial begin
    int lat;
    int n;
    @(negedge clk);
    do_reset();

    // Single request with value=3, range=0 left to time out.
    devctl2 = 16'h0003;
    step(1'b1, 1'b0, 2'd0, 1'b0);
    lat = 0;
    while (!timeout_valid && lat < 100) begin
      step(1'b0, 1'b0, 2'd0, 1'b0);
      lat++;
    end
    check("timeout_latency_in_64_80", int'(lat >= 64 && lat <= 80), 1);
    check("timeout_tag_slot0", timeout_tag, 0);
    step(1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b0, 1'b0, 2'd0, 1'b0);

    // Fill all four slots with a long timeout, then free tag 2 and regrant it.
    devctl2 = 16'h00F0;
    for (int i = 0; i < 4; i++) begin
      check("fill_alloc_tag", alloc_tag, i);
      step(1'b1, 1'b0, 2'd0, 1'b0);
    end
    check("full_req_ready", req_ready, 0);
    check("full_outstanding", outstanding, 4);
    step(1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b0);
    check("freed_req_ready", req_ready, 1);
    check("freed_alloc_tag", alloc_tag, 2);
    step(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), 1'b0);

    // Completion to a free slot.
    step(1'b0, 1'b1, 2'd1, 1'b0);
    check("unexp_pulse", cpl_unexpected, 1);
    check("unexp_outstanding", outstanding, 0);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("unexp_one_cycle", cpl_unexpected, 0);

    // Completion on the exact edge slot 0 would expire.
    devctl2 = 16'h0003;
    step(1'b1, 1'b0, 2'd0, 1'b0);
    n = 0;
    while (!(((cyc % P) == P - 1) && rem[0] == 1) && n < 200) begin
      step(1'b0, 1'b0, 2'd0, 1'b0);
      n++;
    end
    check("race_reached", int'(n < 200), 1);
    step(1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 2'd0, 1'b1);
    check("race_no_timeout", timeout_valid, 0);
    check("race_outstanding", outstanding, 0);

    // Expire slots 1 and 3, hold the report, then drain.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 2'd0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b0);
    n = 0;
    while (!(st[1] == 2 && st[3] == 2 && rep_v) && n < 200) begin
      step(1'b0, 1'b0, 2'd0, 1'b0);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 2'd0, 1'b0);
      check("held_valid", timeout_valid, 1);
      check("held_tag1", timeout_tag, 1);
    end
    step(1'b0, 1'b0, 2'd0, 1'b1);
    check("gap_after_accept", timeout_valid, 0);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("next_tag3", timeout_tag, 3);
    step(1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("drained_outstanding", outstanding, 0);

    // Timeout-disable bit: frozen only when the feature is built in.
    devctl2 = 16'h0103;
    step(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b0, 2'd0, 1'b1);
    devctl2 = 16'h0003;
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 2'd0, 1'b1);

    // Mid-operation reset with a timeout pending.
    devctl2 = 16'h0000;
    step(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0);
    do_reset();

    // Random traffic, including devctl2 changes while slots are in flight.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        devctl2 = {7'd0, 1'($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0) ? 4'd1 : 4'd0, 4'($urandom_range(0, 15))};
      end
      step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    req_valid = 1'b0; cpl_valid = 1'b0; timeout_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpl_timeout_sched.md
CPL_TIMEOUT_SCHED -- requirements
Module: cpl_timeout_sched

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 16, meaning clock cycles per timeout tick (2..1024).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port devctl2, input, 16, the DevCtl2 register: [7:4] timeout range, [3:0] timeout value, [8] timeout disable.
REQ-005 The block SHALL have port req_valid, input, 1, a non-posted request wants a tracking slot.
REQ-006 The block SHALL have port req_ready, output, 1, a free slot exists.
REQ-007 The block SHALL have port alloc_tag, output, 2, the slot granted on the req_valid&req_ready cycle.
REQ-008 The block SHALL have port cpl_valid, input, 1, a completion has arrived.
REQ-009 The block SHALL have port cpl_tag, input, 2, the slot being completed.
REQ-010 The block SHALL have port cpl_unexpected, output, 1, a one-cycle pulse when a completion targets a slot that is not PEND.
REQ-011 The block SHALL have port timeout_valid, output, 1, an expired slot awaits report.
REQ-012 The block SHALL have port timeout_tag, output, 2, the expired slot being reported.
REQ-013 The block SHALL have port timeout_ready, input, 1, the consumer accepts the timeout report.
REQ-014 The block SHALL have port outstanding, output, 3, the count of slots in PEND or EXPIRED (0..4).

Function
REQ-015 The block SHALL hold 4 slots, each in one of three states: FREE, PEND or EXPIRED.
REQ-016 The block SHALL drive req_ready = 1 iff any slot is FREE, and alloc_tag = the lowest-index FREE slot (combinational).
REQ-017 On the req_valid&req_ready cycle, the granted slot SHALL become PEND and load a 17-bit down-counter with LIMIT = (value+1) << (4*min(range,3)).
REQ-018 Each slot SHALL latch LIMIT at allocation; later devctl2 changes SHALL NOT affect in-flight slots.
REQ-019 A free-running prescaler SHALL pulse tick once every PRESCALE cycles; on tick, every PEND counter SHALL decrement.
REQ-020 A PEND slot whose counter decrements from 1 to 0 SHALL become EXPIRED on that edge.
REQ-021 cpl_valid with cpl_tag in PEND SHALL set that slot to FREE next cycle; a completion to FREE or EXPIRED SHALL leave the state unchanged and pulse cpl_unexpected.
REQ-022 When a completion and an expiry hit the same slot in the same cycle, the completion SHALL win: the slot becomes FREE and no timeout is reported.
REQ-023 timeout_valid/timeout_tag SHALL be registered, SHALL present the lowest-index EXPIRED slot, and SHALL stay stable until timeout_ready.
REQ-024 On a timeout_valid&timeout_ready cycle, the reported slot SHALL become FREE next cycle; the next report is asserted no earlier than the following cycle.
REQ-025 Allocation, completion and timeout acceptance on distinct slots in the same cycle SHALL all take effect; a slot freed this cycle SHALL NOT be allocatable until the next cycle.
REQ-026 outstanding SHALL be registered and SHALL equal the slot count in PEND or EXPIRED after each edge.

Reset
REQ-027 While reset_n = 0, all slots SHALL be FREE and counters and prescaler SHALL be 0.
REQ-028 While reset_n = 0, the outputs SHALL be req_ready=1, alloc_tag=0, timeout_valid=0, timeout_tag=0, cpl_unexpected=0 and outstanding=0.
REQ-029 Reset asserted mid-operation SHALL discard all tracked requests without reporting any timeout.

Configuration
REQ-030 With macro CPL_TIMEOUT_DISABLE_EN defined, devctl2[8]=1 SHALL freeze all PEND counters, so no slot expires; allocation and completion still operate.
REQ-031 With CPL_TIMEOUT_DISABLE_EN undefined, devctl2[8] SHALL be ignored and timers always run.

Verification
REQ-032 With PRESCALE=16, range=0, value=3: allocate slot 0 and send no completion -> timeout_valid=1, timeout_tag=0 within 64..80 cycles of grant.
REQ-033 Allocate 4 requests -> tags 0,1,2,3, req_ready=0, outstanding=4; complete tag 2 -> req_ready=1 and the next grant is tag 2.
REQ-034 Send cpl_tag=1 while slot 1 is FREE -> cpl_unexpected pulses for 1 cycle and outstanding is unchanged.
REQ-035 Drive completion on the exact expiry cycle of slot 0 -> slot 0 becomes FREE and timeout_valid stays 0.
REQ-036 Expire slots 1 and 3 with timeout_ready=0 for 10 cycles -> timeout_tag=1 is held; then ready=1 -> tag 3 is reported next, and outstanding reaches 0.
REQ-037 With CPL_TIMEOUT_DISABLE_EN defined and devctl2[8]=1 for 1000 cycles -> no timeout; clear the bit -> expiry follows after the remaining ticks.
